// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB3 definitions used by the APB requester and by APB slaves on the
// peripheral fabric.
//   apb_state_e       : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   apb_req_t         : requester-to-slave signals (paddr, pwrite, pwdata)
//   apb_rsp_t         : slave-to-requester signals (prdata, pready, pslverr)
//   DefaultApbTimeout : default ACCESS wait-state limit before abort
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int ApbAddrWidth      = 32;
  localparam int ApbDataWidth      = 32;
  localparam int DefaultApbTimeout = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [ApbAddrWidth-1:0] paddr;
    logic                    pwrite;
    logic [ApbDataWidth-1:0] pwdata;
  } apb_req_t;

  typedef struct packed {
    logic [ApbDataWidth-1:0] prdata;
    logic                    pready;
    logic                    pslverr;
  } apb_rsp_t;

endpackage

// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
// APB3 requester. Converts the core-side single-outstanding req/gnt/rvalid bus
// into APB SETUP/ACCESS transfers, honours slave wait states and pslverr, and
// aborts a transfer whose ACCESS phase stalls for TimeoutCycles cycles.
//
// Ports
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i / gnt_o            : core request valid / accepted this cycle (comb.)
//   addr_i, we_i, wdata_i    : core request address, direction, write data
//   rvalid_o, rdata_o, err_o : one-cycle response pulse with read data / error
//   psel_o, penable_o        : APB phase control
//   pwrite_o, paddr_o,
//   pwdata_o                 : APB transfer attributes, stable SETUP..ACCESS
//   prdata_i, pready_i,
//   pslverr_i                : APB slave response
// -----------------------------------------------------------------------------
module apb_initiator
  import apb_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = DefaultApbTimeout
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // core side
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  // APB side
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [AddrWidth-1:0] paddr_o,
  output logic [DataWidth-1:0] pwdata_o,
  input  logic [DataWidth-1:0] prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i
);

  // A zero TimeoutCycles disables the abort; keep a 1-bit counter so the
  // declarations stay legal.
  localparam bit TimeoutEn = (TimeoutCycles > 0);
  localparam int CntWidth  = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
  // Abort is taken in the ACCESS cycle whose increment would reach the limit,
  // so exactly TimeoutCycles ACCESS cycles run before RESP.
  localparam logic [CntWidth-1:0] CntLast = TimeoutEn ? CntWidth'(TimeoutCycles - 1) : '0;
  localparam logic [CntWidth-1:0] CntMax  = '1;

  apb_state_e           r_state;
  apb_state_e           w_state_next;
  logic [CntWidth-1:0]  r_wait_cnt;
  logic [AddrWidth-1:0] r_paddr;
  logic                 r_pwrite;
  logic [DataWidth-1:0] r_pwdata;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;
  logic                 w_grant;
  logic                 w_complete;
  logic                 w_abort;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and transfer events
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_i) begin
          w_grant      = 1'b1;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        // pready wins over a timeout hitting in the same cycle.
        if (pready_i) begin
          w_complete   = 1'b1;
          w_state_next = RESP;
        end else if (TimeoutEn && (r_wait_cnt == CntLast)) begin
          w_abort      = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait-state counter: cleared on the grant that enters SETUP, counts ACCESS
  // cycles with pready low, saturates rather than wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= '0;
    end else if (w_grant) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !pready_i && (r_wait_cnt != CntMax)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture (held stable for the whole APB transfer) and response
  // capture. prdata/pslverr are only looked at in the completing ACCESS cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_paddr  <= addr_i;
        r_pwrite <= we_i;
        r_pwdata <= we_i ? wdata_i : '0;
      end
      if (w_complete) begin
        r_rdata <= r_pwrite ? '0 : prdata_i;
        r_err   <= pslverr_i;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Phase controls decode the state register, so an asynchronous
  // reset drops psel/penable/rvalid at once. gnt_o is combinational from req_i
  // and is additionally held low while reset is asserted.
  // ---------------------------------------------------------------------------
  assign gnt_o     = w_grant & rst_ni;
  assign psel_o    = (r_state == SETUP) || (r_state == ACCESS);
  assign penable_o = (r_state == ACCESS);
  assign rvalid_o  = (r_state == RESP);
  assign rdata_o   = rvalid_o ? r_rdata : '0;
  assign err_o     = rvalid_o & r_err;
  assign pwrite_o  = r_pwrite;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;

endmodule

// File: tb/tb_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_apb_initiator
// Self-checking bench for apb_initiator (TimeoutCycles = 8). Stimulus pushes
// the expected response (rdata, err, arrival cycle) into a scoreboard queue; a
// monitor pops and compares whenever rvalid_o is high. A behavioural APB slave
// inserts a configurable number of wait states and drives junk on prdata and
// pslverr outside the completing cycle.
// -----------------------------------------------------------------------------
module tb_apb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk_i;
  logic          rst_ni;
  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [DW-1:0] wdata_i;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;

  apb_initiator #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .pwrite_o (pwrite_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // APB slave model. slv_wait < 0 means pready never rises.
  // ---------------------------------------------------------------------------
  int            slv_wait  = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err   = 1'b0;
  int            acc_cnt   = 0;

  initial begin
    pready_i  = 1'b0;
    prdata_i  = 32'hBAD0_BAD0;
    pslverr_i = 1'b1;
  end

  always @(negedge clk_i) begin
    if (psel_o && penable_o) begin
      pready_i = (slv_wait >= 0) && (acc_cnt == slv_wait);
      acc_cnt++;
    end else begin
      pready_i = 1'b0;
      acc_cnt  = 0;
    end
    prdata_i  = pready_i ? slv_rdata : 32'hBAD0_BAD0;
    pslverr_i = pready_i ? slv_err : 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Response monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin
    exp_t e;
    if (rvalid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rvalid @cycle %0d: got rvalid 1, expected no response", cyc);
      end else begin
        e = sb_q.pop_front();
        check("rsp_rdata", rdata_o, e.rdata);
        check("rsp_err", {31'b0, err_o}, {31'b0, e.err});
        check("rsp_cycle", cyc, e.cyc);
        check("resp_psel", {30'b0, psel_o, penable_o}, 32'h0);
      end
    end else begin
      check("quiet_rdata_err", {rdata_o[30:0], err_o}, 32'h0);
    end
    if (req_i && (psel_o || penable_o || rvalid_o)) check("no_gnt_busy", {31'b0, gnt_o}, 32'h0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < 40)) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL response_bound: got %0d responses outstanding after 40 cycles, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // One transfer: grant at cycle 0, SETUP/ACCESS attribute checks at 1 and 2,
  // request inputs scrambled after the grant, response checked by the monitor.
  task automatic xfer(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wdata,
                      input int wait_n, input logic [DW-1:0] prd, input logic perr,
                      input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [DW-1:0] exp_pw;
    exp_pw = we ? wdata : '0;
    @(negedge clk_i);
    slv_wait  = wait_n;
    slv_rdata = prd;
    slv_err   = perr;
    req_i     = 1'b1;
    addr_i    = addr;
    we_i      = we;
    wdata_i   = wdata;
    #1;
    check("gnt_c0", {31'b0, gnt_o}, 32'h1);
    sb_q.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + exp_lat});
    @(negedge clk_i);
    req_i   = 1'b0;
    addr_i  = 32'hFFFF_FFF0;
    we_i    = ~we;
    wdata_i = ~wdata;
    #1;
    check("setup_sel_en", {30'b0, psel_o, penable_o}, 32'h2);
    check("setup_paddr", paddr_o, addr);
    check("setup_pwrite", {31'b0, pwrite_o}, {31'b0, we});
    check("setup_pwdata", pwdata_o, exp_pw);
    @(negedge clk_i);
    #1;
    check("access_sel_en", {30'b0, psel_o, penable_o}, 32'h3);
    check("access_paddr", paddr_o, addr);
    check("access_pwdata", pwdata_o, exp_pw);
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_ni  = 1'b0;
    req_i   = 1'b0;
    addr_i  = '0;
    we_i    = 1'b0;
    wdata_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ctrl", {28'b0, gnt_o, psel_o, penable_o, rvalid_o}, 32'h0);
    check("rst_paddr", paddr_o, 32'h0);
    check("rst_pwdata", pwdata_o, 32'h0);
    check("rst_pwrite_err", {30'b0, pwrite_o, err_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zero-wait write: response at cycle 3, rdata forced to 0 for writes.
    xfer(32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 0, 32'h7777_7777, 1'b0, 32'h0, 1'b0, 3);
    // Read with 3 wait states (pslverr junk high while waiting is ignored).
    xfer(32'h0000_0004, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 6);
    // Read completing with pslverr in the first ACCESS cycle.
    xfer(32'h0000_0010, 1'b0, 32'h0, 0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 3);
    // Slave never ready: 8 ACCESS cycles (2..9), abort response at cycle 10.
    xfer(32'h0000_0014, 1'b0, 32'h0, -1, 32'h5555_5555, 1'b0, 32'h0, 1'b1, 10);
    // pready in the 8th ACCESS cycle, where the timeout would hit: completes.
    xfer(32'h0000_000C, 1'b1, 32'h0000_00A5, 7, 32'h6666_6666, 1'b0, 32'h0, 1'b0, 10);

    // Back-to-back with req_i held high: grants at cycles 0 and 4.
    @(negedge clk_i);
    slv_wait  = 0;
    slv_rdata = 32'h55AA_1234;
    slv_err   = 1'b0;
    req_i     = 1'b1;
    addr_i    = 32'h0000_0020;
    we_i      = 1'b1;
    wdata_i   = 32'h1111_2222;
    #1;
    check("b2b_gnt_c0", {31'b0, gnt_o}, 32'h1);
    sb_q.push_back('{rdata: 32'h0, err: 1'b0, cyc: cyc + 3});
    @(negedge clk_i);
    addr_i  = 32'h0000_0024;
    we_i    = 1'b0;
    wdata_i = 32'h3333_4444;
    #1;
    check("b2b_gnt_c1", {31'b0, gnt_o}, 32'h0);
    check("b2b_first_paddr", paddr_o, 32'h0000_0020);
    check("b2b_first_pwdata", pwdata_o, 32'h1111_2222);
    @(negedge clk_i);
    #1;
    check("b2b_gnt_c2", {31'b0, gnt_o}, 32'h0);
    @(negedge clk_i);
    #1;
    check("b2b_gnt_c3", {31'b0, gnt_o}, 32'h0);
    @(negedge clk_i);
    #1;
    check("b2b_gnt_c4", {31'b0, gnt_o}, 32'h1);
    sb_q.push_back('{rdata: 32'h55AA_1234, err: 1'b0, cyc: cyc + 3});
    @(negedge clk_i);
    req_i = 1'b0;
    #1;
    check("b2b_second_paddr", paddr_o, 32'h0000_0024);
    check("b2b_second_pwrite", {31'b0, pwrite_o}, 32'h0);
    check("b2b_second_pwdata", pwdata_o, 32'h0);
    wait_idle();

    // Reset in the middle of ACCESS: no response may follow.
    @(negedge clk_i);
    slv_wait = -1;
    req_i    = 1'b1;
    addr_i   = 32'h0000_0030;
    we_i     = 1'b0;
    #1;
    check("kill_gnt_c0", {31'b0, gnt_o}, 32'h1);
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("kill_pre_sel_en", {30'b0, psel_o, penable_o}, 32'h3);
    #1;
    rst_ni = 1'b0;
    req_i  = 1'b1;
    #1;
    check("kill_ctrl", {28'b0, gnt_o, psel_o, penable_o, rvalid_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    req_i  = 1'b0;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    #1;
    check("kill_no_rsp", {31'b0, rvalid_o}, 32'h0);

    // Normal write after reset release.
    xfer(32'h0000_0040, 1'b1, 32'hA5A5_5A5A, 1, 32'h0, 1'b0, 32'h0, 1'b0, 4);

    repeat (3) @(negedge clk_i);
    #1;
    check("sb_empty", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
APB3 requester (master) that turns the core-side single-outstanding request/response bus into APB transfers towards peripherals such as the timer and other APB slaves.
It runs the SETUP/ACCESS phase sequence and honours slave wait states (pready) and errors (pslverr).
It aborts a transfer that stalls too long, using a wait-state timeout.
It sits between the core data-port interconnect and the peripheral APB fabric, in the clk_i domain.

Parameters:
AddrWidth, 32, width of addr_i / paddr_o
DataWidth, 32, width of wdata_i / rdata_o / pwdata_o / prdata_i
TimeoutCycles, 256, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  1  core request valid
gnt_o  out  1  request accepted this cycle (combinational)
addr_i  in  AddrWidth  request byte address
we_i  in  1  1 = write, 0 = read
wdata_i  in  DataWidth  write data
rvalid_o  out  1  response valid, one-cycle pulse
rdata_o  out  DataWidth  read data, valid with rvalid_o
err_o  out  1  response error (pslverr or timeout), valid with rvalid_o
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  AddrWidth  APB address
pwdata_o  out  DataWidth  APB write data
prdata_i  in  DataWidth  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Assertion of rst_ni mid-transfer drops psel_o/penable_o immediately (async). No response is issued for the killed transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: gnt_o = req_i. On grant, register addr_i, we_i and wdata_i into paddr_o, pwrite_o and pwdata_o; go to SETUP. For reads, pwdata_o is registered as 0.
- SETUP (one cycle): psel_o=1, penable_o=0; go to ACCESS.
- ACCESS: psel_o=1, penable_o=1. paddr_o, pwrite_o and pwdata_o stay stable from SETUP through the end of ACCESS.
  - pready_i=1: register rdata (prdata_i for reads, 0 for writes) and err (pslverr_i); go to RESP.
  - pready_i=0: increment the wait counter. If TimeoutCycles!=0 and the counter reaches TimeoutCycles, abort: register err=1 and rdata=0, then go to RESP.
- RESP (one cycle): rvalid_o=1 with rdata_o and err_o; psel_o=0, penable_o=0; go to IDLE.
- rdata_o and err_o return to 0 when rvalid_o is low.
- gnt_o is 0 in every state except IDLE. Only one transfer is outstanding at a time.
- Latency: grant at cycle 0, SETUP at 1, ACCESS at 2. With zero wait states, rvalid_o is at cycle 3. Each wait state adds 1 cycle.
- Back-to-back: next grant is possible in the cycle after RESP. Minimum period is 4 cycles per transfer.
- Wait counter: width clog2(TimeoutCycles+1), cleared on entry to SETUP, saturating.
- pslverr_i is sampled only when psel_o, penable_o and pready_i are all high. prdata_i is likewise sampled only in that cycle.
- Abort when pready_i rises in the same cycle the counter hits the limit: pready_i wins, so this is a normal completion.
- A change of req_i or addr_i after grant has no effect on the transfer.
- Address alignment is not checked; addr_i is passed through unchanged.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS, RESP}
  - APB request/response struct typedefs (paddr, pwrite, pwdata / prdata, pready, pslverr), shared with APB slaves
  - constant DefaultApbTimeout = 256
- No sub-module: FSM, capture registers and timeout counter form one module.

Test Plan:
- Write 0xDEADBEEF to 0x08 with slave pready_i tied 1.
  - gnt_o at cycle 0; psel_o=1/penable_o=0 at cycle 1; penable_o=1 at cycle 2.
  - rvalid_o=1, err_o=0, rdata_o=0 at cycle 3.
  - paddr_o=0x08 and pwdata_o=0xDEADBEEF held across cycles 1-2.
- Read 0x04 with slave returning 0x12345678 after 3 wait states.
  - ACCESS lasts 4 cycles; rvalid_o at cycle 6 with rdata_o=0x12345678, err_o=0.
- Read with pslverr_i=1 and pready_i=1 in the first ACCESS cycle.
  - rvalid_o at cycle 3 with err_o=1.
- TimeoutCycles=8, slave never asserts pready_i.
  - Exactly 8 ACCESS cycles, then RESP with err_o=1, rdata_o=0.
  - psel_o=0 in RESP; next request is granted normally.
- Two queued requests with req_i held high.
  - Grants at cycles 0 and 4; no gnt_o during SETUP/ACCESS/RESP.
  - Second transfer carries the second address/data.
- Assert rst_ni low during ACCESS.
  - psel_o, penable_o, rvalid_o and gnt_o go 0 immediately; no response pulse is issued.
  - After release, a new write completes normally.
